pakin_asm: RTL

- Receive side of the packetised link: consumes the narrow packet stream produced by the packet-out stage and rebuilds full messages from it.
- Collects TOT_PKS packets in index order and presents each complete message on an in-style output channel for the downstream cell.
- Uses 4-phase req/ack on both sides.
- Double-buffered: an assembly register plus an output register, so assembly of message N+1 can overlap delivery of message N.

---
 rtl/pakin_asm.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pakin_asm.sv
// Packet receive/assembly stage: rebuilds full messages from indexed packets
// and hands each one to the downstream cell over a double-buffered 4-phase link.
module pakin_asm #(
   parameter int PSZ         = 4,
   parameter int ASZ         = 6,
   parameter int DSZ         = 4,
   parameter int RSZ         = 4,
   parameter int MSZ         = 2*ASZ+DSZ+RSZ,
   parameter int TOT_PKS     = MSZ/PSZ+1,
   parameter int PIW         = (TOT_PKS > 1) ? $clog2(TOT_PKS) : 1,
   parameter int RCV_REQ_CKS = 2,
   parameter int SND_ACK_CKS = 2
) (
   input  logic           gch_clk,
   input  logic           gch_reset,
   output logic           gch_ready,
   input  logic [PSZ-1:0] rcv0_pakio,
   input  logic [PIW-1:0] rcv0_pidx,
   input  logic           rcv0_req,
   output logic           rcv0_ack,
   output logic [MSZ-1:0] snd0_msg,
   output logic           snd0_req,
   input  logic           snd0_ack,
   output logic           err_seq
);

   localparam int AW = TOT_PKS*PSZ;
   localparam logic [PIW-1:0] LAST = PIW'(TOT_PKS-1);

   typedef enum logic {COLLECT, ACKHI} rstate_t;

   rstate_t                state;
   logic                   init_q;
   logic [RCV_REQ_CKS-1:0] rq_h;
   logic [SND_ACK_CKS-1:0] sa_h;
   logic [AW-1:0]          asm_q;
   logic [AW-1:0]          asm_nx;
   logic [PIW-1:0]         exp_idx;
   logic                   out_full;
   logic                   s_wait;

   logic rq_hi, rq_lo, sa_hi, sa_lo;
   logic hit, is_last, freeing, can_fill;

   // a level only counts once every sample in the history agrees
   assign rq_hi = &rq_h;
   assign rq_lo = ~|rq_h;
   assign sa_hi = &sa_h;
   assign sa_lo = ~|sa_h;

   assign hit      = (rcv0_pidx == exp_idx);
   assign is_last  = (exp_idx == LAST);
   assign freeing  = s_wait & sa_lo;
   assign can_fill = ~out_full | freeing;

   always_comb begin
      asm_nx = asm_q;
      asm_nx[int'(exp_idx)*PSZ +: PSZ] = rcv0_pakio;
   end

   always_ff @(posedge gch_clk) begin
      if (gch_reset || !init_q) begin
         init_q    <= ~gch_reset;
         gch_ready <= 1'b0;
         state     <= COLLECT;
         rq_h      <= '0;
         sa_h      <= '0;
         asm_q     <= '0;
         exp_idx   <= '0;
         out_full  <= 1'b0;
         s_wait    <= 1'b0;
         rcv0_ack  <= 1'b0;
         snd0_req  <= 1'b0;
         snd0_msg  <= '0;
         err_seq   <= 1'b0;
      end else begin
         gch_ready <= 1'b1;
         rq_h      <= (rq_h << 1) | RCV_REQ_CKS'(rcv0_req);
         sa_h      <= (sa_h << 1) | SND_ACK_CKS'(snd0_ack);
         err_seq   <= 1'b0;

         if (s_wait) begin
            if (sa_lo) begin
               out_full <= 1'b0;
               s_wait   <= 1'b0;
            end
         end else if (snd0_req) begin
            if (sa_hi) begin
               snd0_req <= 1'b0;
               s_wait   <= 1'b1;
            end
         end else if (out_full) begin
            snd0_req <= 1'b1;
         end

         // a fill below overrides a same-cycle free above
         unique case (state)
            COLLECT: begin
               if (rq_hi) begin
                  if (hit && !is_last) begin
                     asm_q    <= asm_nx;
                     exp_idx  <= exp_idx + 1'b1;
                     rcv0_ack <= 1'b1;
                     state    <= ACKHI;
                  end else if (hit) begin
                     if (can_fill) begin
                        asm_q    <= asm_nx;
                        snd0_msg <= asm_nx[MSZ-1:0];
                        out_full <= 1'b1;
                        s_wait   <= 1'b0;
                        exp_idx  <= '0;
                        rcv0_ack <= 1'b1;
                        state    <= ACKHI;
                     end
                  end else if (rcv0_pidx == '0) begin
                     asm_q    <= AW'(rcv0_pakio);
                     exp_idx  <= PIW'(1);
                     rcv0_ack <= 1'b1;
                     state    <= ACKHI;
                  end else begin
                     err_seq  <= 1'b1;
                     rcv0_ack <= 1'b1;
                     state    <= ACKHI;
                  end
               end
            end
            ACKHI: begin
               if (rq_lo) begin
                  rcv0_ack <= 1'b0;
                  state    <= COLLECT;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule
